// File: rtl/mvmul_pipe.sv
// Pipelined fixed-point matrix-vector element multiplier with valid/ready flow control.
// Optional per-row saturating sums when MVMUL_PIPE_ROWSUM_EN is defined (adds one stage).

module mvmul_lane #(
  parameter int DW         = 32,
  parameter int FRAC       = 16,
  parameter int MUL_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ld,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] p
);
  logic [DW-1:0]                  a_r, b_r;
  logic [MUL_STAGES-1:0][DW-1:0]  p_pipe;
  logic signed [2*DW-1:0]         ax, bx, full, sh;
  logic [DW:0]                    hi;
  logic [DW-1:0]                  sat_p;

  assign ax   = {{DW{a_r[DW-1]}}, a_r};
  assign bx   = {{DW{b_r[DW-1]}}, b_r};
  assign full = ax * bx;
  assign sh   = full >>> FRAC;
  assign hi   = sh[2*DW-1:DW-1];

  // Result fits when every bit above the DW-bit sign position matches it.
  always_comb begin
    sat_p = sh[DW-1:0];
    if (!((&hi) || !(|hi)))
      sat_p = sh[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      p_pipe <= '0;
    end else begin
      if (ld) begin
        a_r <= a;
        b_r <= b;
      end
      if (en) begin
        p_pipe[0] <= sat_p;
        for (int k = 1; k < MUL_STAGES; k++) p_pipe[k] <= p_pipe[k-1];
      end
    end
  end

  assign p = p_pipe[MUL_STAGES-1];
endmodule

module mvmul_pipe #(
  parameter int ROWS       = 6,
  parameter int COLS       = 6,
  parameter int DW         = 32,
  parameter int FRAC       = 16,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*COLS*DW-1:0] mat,
  input  logic [COLS*DW-1:0]      vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROWS*COLS*DW-1:0] prod,
  output logic [15:0]             done_cnt
`ifdef MVMUL_PIPE_ROWSUM_EN
  ,
  output logic [ROWS*DW-1:0]      rowsum
`endif
);
  localparam int N = ROWS * COLS;
`ifdef MVMUL_PIPE_ROWSUM_EN
  localparam int STAGES = 2 + MUL_STAGES;
`else
  localparam int STAGES = 1 + MUL_STAGES;
`endif

  logic              en, ld;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [N-1:0][DW-1:0] lane_p;

  // Whole pipeline advances together; it freezes only when the head beat is blocked.
  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign ld        = en & in_valid;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld_q <= '0;
    else if (en) vld_q <= vld_pipe[STAGES-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 16'd1;
  end

  for (genvar idx = 0; idx < N; idx++) begin : g_lane
    mvmul_lane #(.DW(DW), .FRAC(FRAC), .MUL_STAGES(MUL_STAGES)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .ld  (ld),
      .a   (mat[idx*DW +: DW]),
      .b   (vec[(idx/ROWS)*DW +: DW]),
      .p   (lane_p[idx])
    );
  end

`ifdef MVMUL_PIPE_ROWSUM_EN
  localparam int AW = DW + 5;
  logic [N-1:0][DW-1:0]    prod_d;
  logic [ROWS-1:0][DW-1:0] rs_next, rs_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic signed [AW-1:0] acc;
    logic [AW-DW:0]       hi;

    // Accumulate wide so only the final sum is clipped.
    always_comb begin
      acc = '0;
      for (int j = 0; j < COLS; j++) acc = acc + AW'($signed(lane_p[j*ROWS+i]));
    end

    assign hi = acc[AW-1:DW-1];
    assign rs_next[i] = ((&hi) || !(|hi)) ? acc[DW-1:0] :
                        (acc[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_d <= '0;
      rs_q   <= '0;
    end else if (en) begin
      prod_d <= lane_p;
      rs_q   <= rs_next;
    end
  end

  assign prod   = prod_d;
  assign rowsum = rs_q;
`else
  assign prod = lane_p;
`endif
endmodule

// File: tb/tb_mvmul_pipe.sv
// Self-checking bench for mvmul_pipe: directed tables, stall/reset sequences,
// and randomized traffic scored against an arithmetic reference model.

module tb_mvmul_pipe;
  localparam int ROWS = 6, COLS = 6, DW = 32, FRAC = 16, MS = 2;
  localparam int N = ROWS * COLS;
`ifdef MVMUL_PIPE_ROWSUM_EN
  localparam int LAT = 2 + MS;
`else
  localparam int LAT = 1 + MS;
`endif

  logic               clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic               in_ready, out_valid;
  logic [N*DW-1:0]    mat = '0, prod;
  logic [COLS*DW-1:0] vec = '0;
  logic [15:0]        done_cnt;
`ifdef MVMUL_PIPE_ROWSUM_EN
  logic [ROWS*DW-1:0] rowsum;
`endif

  always #5 clk = ~clk;

  mvmul_pipe #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .FRAC(FRAC), .MUL_STAGES(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat       (mat),
    .vec       (vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .done_cnt  (done_cnt)
`ifdef MVMUL_PIPE_ROWSUM_EN
    ,
    .rowsum    (rowsum)
`endif
  );

  typedef struct packed {
    logic [N*DW-1:0]    p;
    logic [ROWS*DW-1:0] rs;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t q[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
    return v[31:0];
  endfunction

  // Q16.16 multiply, floor shift, clip; row sums add the clipped products then clip once.
  function automatic exp_t model(input logic [N*DW-1:0] m, input logic [COLS*DW-1:0] v);
    exp_t   e;
    longint a, b, s;
    e = '0;
    for (int idx = 0; idx < N; idx++) begin
      a = longint'($signed(m[idx*DW +: DW]));
      b = longint'($signed(v[(idx/ROWS)*DW +: DW]));
      e.p[idx*DW +: DW] = sat32((a * b) >>> FRAC);
    end
    for (int i = 0; i < ROWS; i++) begin
      s = 0;
      for (int j = 0; j < COLS; j++) s += longint'($signed(e.p[(j*ROWS+i)*DW +: DW]));
      e.rs[i*DW +: DW] = sat32(s);
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_elem();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF0000;
      1:       return 32'h80000000;
      2:       return $urandom_range(0, 32'h0003FFFF);
      3:       return 32'h0 - $urandom_range(0, 32'h0003FFFF);
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_rand();
    for (int i = 0; i < N; i++)    mat[i*DW +: DW] = rnd_elem();
    for (int j = 0; j < COLS; j++) vec[j*DW +: DW] = rnd_elem();
  endtask

  task automatic fill(input logic [31:0] mv, input logic [31:0] vv);
    for (int i = 0; i < N; i++)    mat[i*DW +: DW] = mv;
    for (int j = 0; j < COLS; j++) vec[j*DW +: DW] = vv;
  endtask

  task automatic reset_dut();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_out(input int bound);
    int n = 0;
    #1;
    while (!out_valid && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    if (!out_valid) chk("wait_out_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard: push model result on input handshake, compare on output handshake.
  exp_t mon_e;
  int   mon_k;
  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else begin
          mon_e = q.pop_front();
          mon_k = 0;
          for (int k = N - 1; k >= 0; k--)
            if (prod[k*DW +: DW] !== mon_e.p[k*DW +: DW]) mon_k = k;
          chk($sformatf("prod[%0d]", mon_k), 64'(prod[mon_k*DW +: DW]), 64'(mon_e.p[mon_k*DW +: DW]));
`ifdef MVMUL_PIPE_ROWSUM_EN
          mon_k = 0;
          for (int k = ROWS - 1; k >= 0; k--)
            if (rowsum[k*DW +: DW] !== mon_e.rs[k*DW +: DW]) mon_k = k;
          chk($sformatf("rowsum[%0d]", mon_k), 64'(rowsum[mon_k*DW +: DW]), 64'(mon_e.rs[mon_k*DW +: DW]));
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(model(mat, vec));
    end
  end

  vec_t        tbl[8];
  logic [N*DW-1:0] snap;
  bit          have_snap;
  int          sent;

  initial begin
    tbl[0] = '{32'hFFFE8000, 32'h00020000, 32'hFFFD0000};
    tbl[1] = '{32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF};
    tbl[2] = '{32'h80000000, 32'h00020000, 32'h80000000};
    tbl[3] = '{32'h00010000, 32'h00010000, 32'h00010000};
    tbl[4] = '{32'hFFFF0000, 32'hFFFF0000, 32'h00010000};
    tbl[5] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[6] = '{32'h00008000, 32'h00008000, 32'h00004000};
    tbl[7] = '{32'h00000000, 32'h12345678, 32'h00000000};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done_cnt",  64'(done_cnt),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_prod_zero", 64'(|prod),     64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single beat latency
    fill(32'h00020000, 32'h00030000);
    in_valid = 1'b1;
    #1 chk("first_edge_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_c1", 64'(out_valid), 64'(LAT == 1));
    for (int c = 2; c <= LAT; c++) begin
      @(negedge clk); #1;
      chk($sformatf("lat_c%0d", c), 64'(out_valid), 64'(c == LAT));
    end
    chk("lat_prod0",  64'(prod[0 +: DW]),        64'h00060000);
    chk("lat_prodN1", 64'(prod[(N-1)*DW +: DW]), 64'h00060000);
    @(negedge clk); #1;
    chk("lat_done_cnt", 64'(done_cnt), 64'd1);

    // Arithmetic table
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      mat = '0;
      vec = '0;
      mat[0 +: DW]  = tbl[t].a;
      mat[DW +: DW] = tbl[t].a;
      vec[0 +: DW]  = tbl[t].b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(20);
      chk($sformatf("tbl%0d_p0", t), 64'(prod[0 +: DW]),  64'(tbl[t].exp));
      chk($sformatf("tbl%0d_p1", t), 64'(prod[DW +: DW]), 64'(tbl[t].exp));
    end
    @(negedge clk);

    // 10 back-to-back beats with a 4-cycle downstream stall
    reset_dut();
    sent = 0;
    have_snap = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (sent < 10);
      drive_rand();
      vec[0 +: DW] = 32'h00010000;
      mat[0 +: DW] = (sent + 1) << 16;
      #1;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (have_snap) chk("stall_hold", 64'(prod === snap), 64'd1);
        snap = prod;
        have_snap = 1;
      end else have_snap = 0;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("b2b_done_cnt", 64'(done_cnt), 64'd10);
    chk("b2b_drained",  64'(q.size()), 64'd0);

    // Randomized traffic, including garbage on idle input cycles
    reset_dut();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      drive_rand();
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    #1 chk("rand_drained", 64'(q.size()), 64'd0);

    // Reset with beats in flight
    reset_dut();
    in_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      drive_rand();
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_done_cnt",  64'(done_cnt),  64'd0);
    chk("midrst_prod_zero", 64'(|prod),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    fill(32'h00030000, 32'hFFFF8000);
    in_valid = 1'b1;
    #1 chk("postrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("postrst_c1", 64'(out_valid), 64'(LAT == 1));
    for (int c = 2; c <= LAT; c++) begin
      @(negedge clk); #1;
      chk($sformatf("postrst_c%0d", c), 64'(out_valid), 64'(c == LAT));
    end
    chk("postrst_prod0", 64'(prod[0 +: DW]), 64'hFFFE8000);
    repeat (4) @(negedge clk);
    #1 chk("postrst_done_cnt", 64'(done_cnt), 64'd1);

`ifdef MVMUL_PIPE_ROWSUM_EN
    // Row sums: plain and saturating
    reset_dut();
    fill(32'h00010000, 32'h00010000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(20);
    chk("rowsum_unit", 64'(rowsum[0 +: DW]), 64'h00060000);
    @(negedge clk);
    fill(32'h7FFF0000, 32'h7FFF0000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(20);
    chk("rowsum_sat", 64'(rowsum[(ROWS-1)*DW +: DW]), 64'h7FFFFFFF);
    @(negedge clk);
`endif

    // done_cnt wrap after 65536 handshakes
    reset_dut();
    fill(32'h00010000, 32'h00020000);
    in_valid = 1'b1;
    repeat (65535) @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    #1 chk("cnt_ffff", 64'(done_cnt), 64'hFFFF);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(20);
    @(negedge clk); #1;
    chk("cnt_wrap", 64'(done_cnt), 64'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
